// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode encodings, FSM/shift enums and op classification for seq_alu
// SEQ_ALU_DIV_EN selects whether DIV/MOD count as multi-cycle ops.
package alu_pkg;

  localparam logic [4:0] OP_PASS = 5'b00000;
  localparam logic [4:0] OP_ADD  = 5'b00001;
  localparam logic [4:0] OP_SUB  = 5'b00010;
  localparam logic [4:0] OP_MULS = 5'b00011;
  localparam logic [4:0] OP_MULU = 5'b00100;
  localparam logic [4:0] OP_DIV  = 5'b00101;
  localparam logic [4:0] OP_MOD  = 5'b00110;
  localparam logic [4:0] OP_NAND = 5'b01000;
  localparam logic [4:0] OP_NOR  = 5'b01001;
  localparam logic [4:0] OP_AND  = 5'b01010;
  localparam logic [4:0] OP_XNOR = 5'b01011;
  localparam logic [4:0] OP_OR   = 5'b01100;
  localparam logic [4:0] OP_XOR  = 5'b01101;
  localparam logic [4:0] OP_NOT  = 5'b01110;
  localparam logic [4:0] OP_LSR  = 5'b11000;
  localparam logic [4:0] OP_LSL  = 5'b11001;
  localparam logic [4:0] OP_ASR  = 5'b11010;
  localparam logic [4:0] OP_ASL  = 5'b11011;
  localparam logic [4:0] OP_ROR  = 5'b11100;

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} alu_state_t;
  typedef enum logic [1:0] {SH_LSL, SH_LSR, SH_ASR, SH_ROR} shift_mode_t;

  function automatic logic is_multicycle(input logic [4:0] op);
`ifdef SEQ_ALU_DIV_EN
    return (op == OP_MULS) || (op == OP_MULU) || (op == OP_DIV) || (op == OP_MOD);
`else
    return (op == OP_MULS) || (op == OP_MULU);
`endif
  endfunction

endpackage

// File: rtl/seq_alu_shifter.sv
// rtl/seq_alu_shifter.sv - combinational barrel shifter/rotator with last-bit-out carry
module seq_alu_shifter
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  shift_mode_t      i_mode,
  input  logic [WIDTH-1:0] i_x,
  input  logic [SHW-1:0]   i_amt,
  output logic [WIDTH-1:0] o_r,
  output logic             o_c
);

  logic [WIDTH:0]   w_ext;
  logic [WIDTH-1:0] w_rot;

  // An extra guard bit beside the operand catches the last bit shifted out.
  always_comb begin
    w_ext = '0;
    w_rot = '0;
    o_r   = i_x;
    o_c   = 1'b0;
    case (i_mode)
      SH_LSL: begin
        w_ext = {1'b0, i_x} << i_amt;
        o_r   = w_ext[WIDTH-1:0];
        o_c   = w_ext[WIDTH];
      end
      SH_LSR: begin
        w_ext = {i_x, 1'b0} >> i_amt;
        o_r   = w_ext[WIDTH:1];
        o_c   = w_ext[0];
      end
      SH_ASR: begin
        w_ext = $signed({i_x, 1'b0}) >>> i_amt;
        o_r   = w_ext[WIDTH:1];
        o_c   = w_ext[0];
      end
      SH_ROR: begin
        w_rot = (i_x >> i_amt) | (i_x << (WIDTH - int'(i_amt)));
        o_r   = w_rot;
        o_c   = (i_amt != '0) && w_rot[WIDTH-1];
      end
      default: begin
        o_r = i_x;
        o_c = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/seq_alu.sv
// rtl/seq_alu.sv - registered valid/ready ALU with iterative multiply and divide
// Define SEQ_ALU_DIV_EN to build the restoring divider; otherwise DIV/MOD decode as illegal.
module seq_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] r,
  output logic [WIDTH-1:0] r_hi,
  output logic             negative,
  output logic             zero,
  output logic             cout,
  output logic             overflow,
  output logic             div_invalid,
  output logic             illegal_op
);

  localparam logic [SHW-1:0] CNT_LAST = SHW'(WIDTH - 1);

  alu_state_t         r_state;
  logic               r_out_valid;
  logic [WIDTH-1:0]   r_res, r_res_hi;
  logic               r_n, r_z, r_c, r_v, r_dinv, r_ill;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opnd;
  logic [SHW-1:0]     r_cnt;
  logic               r_neg, r_muls;

  logic               w_busy, w_accept, w_div_zero, w_start_multi, w_last;
  shift_mode_t        w_sh_mode;
  logic [WIDTH-1:0]   w_sh_r;
  logic               w_sh_c;
  logic [WIDTH:0]     w_add, w_sub;
  logic [WIDTH-1:0]   w_res;
  logic               w_n, w_z, w_c, w_v, w_dinv, w_ill, w_nz_en;
  logic [WIDTH-1:0]   w_mul_a, w_mul_b;
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_next, w_step, w_prod;
  logic [WIDTH-1:0]   w_fin_r, w_fin_hi;
  logic               w_fin_n, w_fin_z, w_fin_v;

  assign w_busy        = (r_state == S_MUL) || (r_state == S_DIV);
  assign in_ready      = !w_busy && (!r_out_valid || out_ready);
  assign w_accept      = in_valid && in_ready;
  assign w_div_zero    = ((opcode == OP_DIV) || (opcode == OP_MOD)) && (y == '0);
  assign w_start_multi = is_multicycle(opcode) && !w_div_zero;
  assign w_last        = (r_cnt == CNT_LAST);

  always_comb begin
    case (opcode)
      OP_LSR:  w_sh_mode = SH_LSR;
      OP_ASR:  w_sh_mode = SH_ASR;
      OP_ROR:  w_sh_mode = SH_ROR;
      default: w_sh_mode = SH_LSL;
    endcase
  end

  seq_alu_shifter #(.WIDTH(WIDTH), .SHW(SHW)) u_shifter (
    .i_mode (w_sh_mode),
    .i_x    (x),
    .i_amt  (y[SHW-1:0]),
    .o_r    (w_sh_r),
    .o_c    (w_sh_c)
  );

  assign w_add = {1'b0, x} + {1'b0, y};
  assign w_sub = {1'b0, x} + {1'b0, ~y} + {{WIDTH{1'b0}}, 1'b1};

  always_comb begin
    w_res   = '0;
    w_c     = 1'b0;
    w_v     = 1'b0;
    w_dinv  = 1'b0;
    w_ill   = 1'b0;
    w_nz_en = 1'b1;
    case (opcode)
      OP_PASS: w_res = x;
      OP_ADD: begin
        w_res = w_add[WIDTH-1:0];
        w_c   = w_add[WIDTH];
        w_v   = (x[WIDTH-1] == y[WIDTH-1]) && (w_add[WIDTH-1] != x[WIDTH-1]);
      end
      OP_SUB: begin
        w_res = w_sub[WIDTH-1:0];
        w_c   = w_sub[WIDTH];
        w_v   = (x[WIDTH-1] != y[WIDTH-1]) && (w_sub[WIDTH-1] != x[WIDTH-1]);
      end
      OP_NAND: w_res = ~(x & y);
      OP_NOR:  w_res = ~(x | y);
      OP_AND:  w_res = x & y;
      OP_XNOR: w_res = ~(x ^ y);
      OP_OR:   w_res = x | y;
      OP_XOR:  w_res = x ^ y;
      OP_NOT:  w_res = ~x;
      OP_LSR, OP_LSL, OP_ASR, OP_ROR: begin
        w_res = w_sh_r;
        w_c   = w_sh_c;
      end
      OP_ASL: begin
        w_res = w_sh_r;
        w_c   = w_sh_c;
        w_v   = x[WIDTH-1] != w_sh_r[WIDTH-1];
      end
`ifdef SEQ_ALU_DIV_EN
      // Only reached with y==0; nonzero divisors take the iterative path.
      OP_DIV, OP_MOD: begin
        w_res   = '1;
        w_dinv  = 1'b1;
        w_nz_en = 1'b0;
      end
`endif
      default: begin
        w_ill   = 1'b1;
        w_nz_en = 1'b0;
      end
    endcase
    w_n = w_nz_en && w_res[WIDTH-1];
    w_z = w_nz_en && (w_res == '0);
  end

  assign w_mul_a    = ((opcode == OP_MULS) && x[WIDTH-1]) ? -x : x;
  assign w_mul_b    = ((opcode == OP_MULS) && y[WIDTH-1]) ? -y : y;
  assign w_mul_sum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opnd} : '0);
  assign w_mul_next = {w_mul_sum, r_acc[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
  logic               r_mod;
  logic [WIDTH:0]     w_div_tmp;
  logic [WIDTH-1:0]   w_div_sub;
  logic               w_div_ge;
  logic [2*WIDTH-1:0] w_div_next;

  // Upper half holds the partial remainder, lower half shifts dividend out and quotient in.
  assign w_div_tmp  = r_acc[2*WIDTH-1:WIDTH-1];
  assign w_div_ge   = w_div_tmp >= {1'b0, r_opnd};
  assign w_div_sub  = w_div_tmp[WIDTH-1:0] - r_opnd;
  assign w_div_next = {(w_div_ge ? w_div_sub : w_div_tmp[WIDTH-1:0]), r_acc[WIDTH-2:0], w_div_ge};
  assign w_step     = (r_state == S_DIV) ? w_div_next : w_mul_next;
`else
  assign w_step     = w_mul_next;
`endif

  always_comb begin
    w_prod   = r_neg ? -w_step : w_step;
    w_fin_r  = w_prod[WIDTH-1:0];
    w_fin_hi = w_prod[2*WIDTH-1:WIDTH];
    w_fin_n  = w_prod[2*WIDTH-1];
    w_fin_z  = (w_prod == '0);
    w_fin_v  = r_muls ? (w_fin_hi != {WIDTH{w_fin_r[WIDTH-1]}}) : (w_fin_hi != '0);
`ifdef SEQ_ALU_DIV_EN
    if (r_state == S_DIV) begin
      w_fin_r  = r_mod ? w_step[2*WIDTH-1:WIDTH] : w_step[WIDTH-1:0];
      w_fin_hi = '0;
      w_fin_n  = w_fin_r[WIDTH-1];
      w_fin_z  = (w_fin_r == '0);
      w_fin_v  = 1'b0;
    end
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_out_valid <= 1'b0;
      r_res       <= '0;
      r_res_hi    <= '0;
      r_n         <= 1'b0;
      r_z         <= 1'b0;
      r_c         <= 1'b0;
      r_v         <= 1'b0;
      r_dinv      <= 1'b0;
      r_ill       <= 1'b0;
      r_acc       <= '0;
      r_opnd      <= '0;
      r_cnt       <= '0;
      r_neg       <= 1'b0;
      r_muls      <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
      r_mod       <= 1'b0;
`endif
    end else begin
      case (r_state)
        S_MUL, S_DIV: begin
          r_acc <= w_step;
          r_cnt <= r_cnt + SHW'(1);
          if (w_last) begin
            r_state     <= S_DONE;
            r_out_valid <= 1'b1;
            r_res       <= w_fin_r;
            r_res_hi    <= w_fin_hi;
            r_n         <= w_fin_n;
            r_z         <= w_fin_z;
            r_c         <= 1'b0;
            r_v         <= w_fin_v;
            r_dinv      <= 1'b0;
            r_ill       <= 1'b0;
          end
        end
        default: begin
          if (r_out_valid && out_ready) begin
            r_out_valid <= 1'b0;
            r_state     <= S_IDLE;
          end
          if (w_accept) begin
            if (w_start_multi) begin
              r_cnt  <= '0;
              r_muls <= (opcode == OP_MULS);
              r_neg  <= (opcode == OP_MULS) && (x[WIDTH-1] ^ y[WIDTH-1]);
`ifdef SEQ_ALU_DIV_EN
              r_mod  <= (opcode == OP_MOD);
`endif
              if ((opcode == OP_MULS) || (opcode == OP_MULU)) begin
                r_state <= S_MUL;
                r_acc   <= {{WIDTH{1'b0}}, w_mul_a};
                r_opnd  <= w_mul_b;
              end else begin
                r_state <= S_DIV;
                r_acc   <= {{WIDTH{1'b0}}, x};
                r_opnd  <= y;
              end
            end else begin
              r_state     <= S_DONE;
              r_out_valid <= 1'b1;
              r_res       <= w_res;
              r_res_hi    <= '0;
              r_n         <= w_n;
              r_z         <= w_z;
              r_c         <= w_c;
              r_v         <= w_v;
              r_dinv      <= w_dinv;
              r_ill       <= w_ill;
            end
          end
        end
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign r           = r_res;
  assign r_hi        = r_res_hi;
  assign negative    = r_n;
  assign zero        = r_z;
  assign cout        = r_c;
  assign overflow    = r_v;
  assign div_invalid = r_dinv;
  assign illegal_op  = r_ill;

endmodule

// File: tb/tb_seq_alu.sv
// tb/tb_seq_alu.sv - directed self-checking bench for seq_alu at WIDTH=16
module tb_seq_alu;

  localparam logic [4:0] T_PASS = 5'b00000, T_ADD = 5'b00001, T_SUB = 5'b00010;
  localparam logic [4:0] T_MULS = 5'b00011, T_MULU = 5'b00100, T_DIV = 5'b00101, T_MOD = 5'b00110;
  localparam logic [4:0] T_NAND = 5'b01000, T_NOR = 5'b01001, T_AND = 5'b01010, T_XNOR = 5'b01011;
  localparam logic [4:0] T_OR = 5'b01100, T_XOR = 5'b01101, T_NOT = 5'b01110;
  localparam logic [4:0] T_LSR = 5'b11000, T_LSL = 5'b11001, T_ASR = 5'b11010;
  localparam logic [4:0] T_ASL = 5'b11011, T_ROR = 5'b11100;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [4:0]  opcode;
  logic [15:0] x, y, r, r_hi;
  logic        negative, zero, cout, overflow, div_invalid, illegal_op;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  seq_alu #(.WIDTH(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .x(x), .y(y), .out_valid(out_valid), .out_ready(out_ready),
    .r(r), .r_hi(r_hi), .negative(negative), .zero(zero), .cout(cout),
    .overflow(overflow), .div_invalid(div_invalid), .illegal_op(illegal_op)
  );

  task automatic do_accept(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b);
    opcode = op; x = a; y = b; in_valid = 1'b1;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        return;
      end
    end
    checks++; errors++;
    $display("FAIL accept_timeout op=%b in_ready=%b required=1", op, in_ready);
    in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int n);
    n = 0;
    while (out_valid !== 1'b1 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; opcode = '0; x = '0; y = '0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if ({r, r_hi} !== 32'h0) begin errors++; $display("FAIL reset_result got=%h exp=0", {r_hi, r}); end
    checks++;
    if ({negative, zero, cout, overflow, div_invalid, illegal_op} !== 6'b0) begin
      errors++; $display("FAIL reset_flags got=%b exp=000000", {negative, zero, cout, overflow, div_invalid, illegal_op});
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_add;
    int n;
    do_accept(T_ADD, 16'h7FFF, 16'h0001);
    wait_valid(n);
    checks++;
    if (n != 0) begin errors++; $display("FAIL add_latency got=%0d exp=0", n); end
    checks++;
    if (r !== 16'h8000 || {negative, zero, cout, overflow} !== 4'b1001) begin
      errors++; $display("FAIL add_ovf got r=%h nzcv=%b exp r=8000 nzcv=1001", r, {negative, zero, cout, overflow});
    end
    do_accept(T_ADD, 16'hFFFF, 16'h0001);
    wait_valid(n);
    checks++;
    if (r !== 16'h0000 || {negative, zero, cout, overflow} !== 4'b0110) begin
      errors++; $display("FAIL add_carry got r=%h nzcv=%b exp r=0000 nzcv=0110", r, {negative, zero, cout, overflow});
    end
  endtask

  task automatic test_sub_back_to_back;
    int n;
    opcode = T_SUB; x = 16'h0005; y = 16'h0005; in_valid = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    opcode = T_NOT; x = 16'h00FF; y = 16'h0000;
    checks++;
    if (out_valid !== 1'b1 || r !== 16'h0000 || {negative, zero, cout, overflow} !== 4'b0110) begin
      errors++; $display("FAIL sub_zero got v=%b r=%h nzcv=%b exp v=1 r=0000 nzcv=0110", out_valid, r, {negative, zero, cout, overflow});
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || r !== 16'hFF00 || {negative, zero, cout, overflow} !== 4'b1000) begin
      errors++; $display("FAIL b2b_not got v=%b r=%h nzcv=%b exp v=1 r=FF00 nzcv=1000", out_valid, r, {negative, zero, cout, overflow});
    end
    do_accept(T_SUB, 16'h0000, 16'h0001);
    wait_valid(n);
    checks++;
    if (r !== 16'hFFFF || {negative, zero, cout, overflow} !== 4'b1000) begin
      errors++; $display("FAIL sub_borrow got r=%h nzcv=%b exp r=FFFF nzcv=1000", r, {negative, zero, cout, overflow});
    end
    do_accept(T_SUB, 16'h8000, 16'h0001);
    wait_valid(n);
    checks++;
    if (r !== 16'h7FFF || {negative, zero, cout, overflow} !== 4'b0011) begin
      errors++; $display("FAIL sub_ovf got r=%h nzcv=%b exp r=7FFF nzcv=0011", r, {negative, zero, cout, overflow});
    end
  endtask

  task automatic test_logic;
    logic [4:0]  t_op [8] = '{T_AND, T_NAND, T_OR, T_NOR, T_XOR, T_XNOR, T_PASS, T_NOT};
    logic [15:0] t_x  [8] = '{16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hF0F0, 16'hAAAA, 16'hAAAA, 16'h1234, 16'h00FF};
    logic [15:0] t_y  [8] = '{16'hFF00, 16'hFF00, 16'h0F0F, 16'h0F0F, 16'h5555, 16'hAAAA, 16'hFFFF, 16'h1111};
    logic [15:0] t_r  [8] = '{16'hF000, 16'h0FFF, 16'hFFFF, 16'h0000, 16'hFFFF, 16'hFFFF, 16'h1234, 16'hFF00};
    logic [3:0]  t_f  [8] = '{4'b1000, 4'b0000, 4'b1000, 4'b0100, 4'b1000, 4'b1000, 4'b0000, 4'b1000};
    int n;
    for (int i = 0; i < 8; i++) begin
      do_accept(t_op[i], t_x[i], t_y[i]);
      wait_valid(n);
      checks++;
      if (n != 0 || r !== t_r[i] || {negative, zero, cout, overflow} !== t_f[i]) begin
        errors++;
        $display("FAIL logic_%0d op=%b got lat=%0d r=%h nzcv=%b exp lat=0 r=%h nzcv=%b", i, t_op[i], n, r, {negative, zero, cout, overflow}, t_r[i], t_f[i]);
      end
    end
  endtask

  task automatic test_mul;
    int n;
    int bad;
    do_accept(T_MULS, 16'hFFFE, 16'h0003);
    bad = 0;
    for (int i = 0; i < 16; i++) begin
      if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
      @(posedge clk); #1;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL muls_busy got=%0d bad cycles exp=0", bad); end
    checks++;
    if (out_valid !== 1'b1 || r_hi !== 16'hFFFF || r !== 16'hFFFA || negative !== 1'b1 || overflow !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL muls_neg got v=%b hi=%h r=%h n=%b v=%b z=%b exp v=1 hi=FFFF r=FFFA n=1 v=0 z=0", out_valid, r_hi, r, negative, overflow, zero);
    end
    do_accept(T_MULU, 16'hFFFF, 16'hFFFF);
    wait_valid(n);
    checks++;
    if (n != 16 || r_hi !== 16'hFFFE || r !== 16'h0001) begin
      errors++; $display("FAIL mulu got lat=%0d hi=%h r=%h exp lat=16 hi=FFFE r=0001", n, r_hi, r);
    end
    do_accept(T_MULS, 16'h8000, 16'h8000);
    wait_valid(n);
    checks++;
    if (r_hi !== 16'h4000 || r !== 16'h0000 || overflow !== 1'b1 || negative !== 1'b0 || zero !== 1'b0) begin
      errors++; $display("FAIL muls_ovf got hi=%h r=%h v=%b n=%b z=%b exp hi=4000 r=0000 v=1 n=0 z=0", r_hi, r, overflow, negative, zero);
    end
    do_accept(T_MULS, 16'h0007, 16'hFFFD);
    wait_valid(n);
    checks++;
    if (r_hi !== 16'hFFFF || r !== 16'hFFEB || overflow !== 1'b0) begin
      errors++; $display("FAIL muls_mixed got hi=%h r=%h v=%b exp hi=FFFF r=FFEB v=0", r_hi, r, overflow);
    end
  endtask

  task automatic test_div;
    int n;
`ifdef SEQ_ALU_DIV_EN
    do_accept(T_DIV, 16'h0064, 16'h0007);
    wait_valid(n);
    checks++;
    if (n != 16 || r !== 16'h000E || r_hi !== 16'h0000 || div_invalid !== 1'b0) begin
      errors++; $display("FAIL div got lat=%0d r=%h hi=%h dinv=%b exp lat=16 r=000E hi=0000 dinv=0", n, r, r_hi, div_invalid);
    end
    do_accept(T_MOD, 16'h0064, 16'h0007);
    wait_valid(n);
    checks++;
    if (n != 16 || r !== 16'h0002) begin
      errors++; $display("FAIL mod got lat=%0d r=%h exp lat=16 r=0002", n, r);
    end
    do_accept(T_DIV, 16'h0064, 16'h0000);
    wait_valid(n);
    checks++;
    if (n != 0 || r !== 16'hFFFF || r_hi !== 16'h0000 || div_invalid !== 1'b1 ||
        {negative, zero, cout, overflow, illegal_op} !== 5'b0) begin
      errors++; $display("FAIL div_zero got lat=%0d r=%h dinv=%b nzcvi=%b exp lat=0 r=FFFF dinv=1 nzcvi=00000", n, r, div_invalid, {negative, zero, cout, overflow, illegal_op});
    end
`else
    do_accept(T_DIV, 16'h0064, 16'h0007);
    wait_valid(n);
    checks++;
    if (n != 0 || r !== 16'h0000 || illegal_op !== 1'b1 || div_invalid !== 1'b0) begin
      errors++; $display("FAIL div_disabled got lat=%0d r=%h ill=%b dinv=%b exp lat=0 r=0000 ill=1 dinv=0", n, r, illegal_op, div_invalid);
    end
    do_accept(T_MOD, 16'h0064, 16'h0000);
    wait_valid(n);
    checks++;
    if (n != 0 || illegal_op !== 1'b1 || div_invalid !== 1'b0) begin
      errors++; $display("FAIL mod_disabled got lat=%0d ill=%b dinv=%b exp lat=0 ill=1 dinv=0", n, illegal_op, div_invalid);
    end
`endif
  endtask

  task automatic test_shift;
    logic [4:0]  t_op [8] = '{T_LSR, T_ROR, T_ROR, T_ASR, T_ASR, T_LSL, T_ASL, T_LSR};
    logic [15:0] t_x  [8] = '{16'h8001, 16'h0001, 16'h0003, 16'h8000, 16'h8004, 16'h8001, 16'h4000, 16'h1234};
    logic [15:0] t_y  [8] = '{16'h0001, 16'h0004, 16'h0001, 16'h0003, 16'h0003, 16'h0001, 16'h0001, 16'h0010};
    logic [15:0] t_r  [8] = '{16'h4000, 16'h1000, 16'h8001, 16'hF000, 16'hF000, 16'h0002, 16'h8000, 16'h1234};
    logic [3:0]  t_f  [8] = '{4'b0010, 4'b0000, 4'b1010, 4'b1000, 4'b1010, 4'b0010, 4'b1001, 4'b0000};
    int n;
    for (int i = 0; i < 8; i++) begin
      do_accept(t_op[i], t_x[i], t_y[i]);
      wait_valid(n);
      checks++;
      if (n != 0 || r !== t_r[i] || {negative, zero, cout, overflow} !== t_f[i]) begin
        errors++;
        $display("FAIL shift_%0d op=%b got lat=%0d r=%h nzcv=%b exp lat=0 r=%h nzcv=%b", i, t_op[i], n, r, {negative, zero, cout, overflow}, t_r[i], t_f[i]);
      end
    end
  endtask

  task automatic test_illegal;
    int n;
    do_accept(5'b11111, 16'h1234, 16'h5678);
    wait_valid(n);
    checks++;
    if (n != 0 || r !== 16'h0000 || r_hi !== 16'h0000 || illegal_op !== 1'b1 ||
        {negative, zero, cout, overflow, div_invalid} !== 5'b0) begin
      errors++; $display("FAIL illegal_11111 got lat=%0d r=%h ill=%b nzcvd=%b exp lat=0 r=0000 ill=1 nzcvd=00000", n, r, illegal_op, {negative, zero, cout, overflow, div_invalid});
    end
    do_accept(5'b00111, 16'h0000, 16'h0000);
    wait_valid(n);
    checks++;
    if (illegal_op !== 1'b1 || zero !== 1'b0) begin
      errors++; $display("FAIL illegal_00111 got ill=%b z=%b exp ill=1 z=0", illegal_op, zero);
    end
    do_accept(T_ADD, 16'h0000, 16'h0000);
    wait_valid(n);
    checks++;
    if (illegal_op !== 1'b0 || zero !== 1'b1) begin
      errors++; $display("FAIL illegal_clear got ill=%b z=%b exp ill=0 z=1", illegal_op, zero);
    end
  endtask

  task automatic test_stall;
    int n;
    int bad;
    do_accept(T_ADD, 16'h0001, 16'h0002);
    out_ready = 1'b0;
    wait_valid(n);
    opcode = T_XOR; x = 16'h00FF; y = 16'h0F0F; in_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b1 || r !== 16'h0003 || {negative, zero, cout, overflow} !== 4'b0000 || in_ready !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold got=%0d bad cycles exp=0", bad); end
    out_ready = 1'b1;
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got=%b exp=1", in_ready); end
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (out_valid !== 1'b1 || r !== 16'h0FF0) begin
      errors++; $display("FAIL stall_next got v=%b r=%h exp v=1 r=0FF0", out_valid, r);
    end
  endtask

  task automatic test_reset_mid_mul;
    int n;
    do_accept(T_MULU, 16'hFFFF, 16'hFFFF);
    repeat (4) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (out_valid !== 1'b0 || {r, r_hi} !== 32'h0 ||
        {negative, zero, cout, overflow, div_invalid, illegal_op} !== 6'b0) begin
      errors++; $display("FAIL mid_mul_reset got v=%b hi=%h r=%h flags=%b exp all zero", out_valid, r_hi, r,
                         {negative, zero, cout, overflow, div_invalid, illegal_op});
    end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL mid_mul_reset_ready got=%b exp=1", in_ready); end
    rst_n = 1'b1;
    do_accept(T_ADD, 16'h0001, 16'h0001);
    wait_valid(n);
    checks++;
    if (n != 0 || r !== 16'h0002 || r_hi !== 16'h0000) begin
      errors++; $display("FAIL post_reset_add got lat=%0d r=%h hi=%h exp lat=0 r=0002 hi=0000", n, r, r_hi);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_add();
    test_sub_back_to_back();
    test_logic();
    test_mul();
    test_div();
    test_shift();
    test_illegal();
    test_stall();
    test_reset_mid_mul();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
